// File: rtl/game_phase_ctrl.sv
// Bunny game phase sequencer: IDLE -> seconds countdown -> timed play -> OVER.
// All outputs are registers; rst clears everything asynchronously.
module game_phase_ctrl #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int COUNTDOWN_S = 3,
  parameter int PLAY_S      = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gamestart,
  input  logic       pause,
  output logic [1:0] phase,
  output logic [3:0] count_digit,
  output logic [6:0] time_left,
  output logic       sec_tick,
  output logic       play_en,
  output logic       game_over
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PS_ZERO = PW'(1'b0);
  localparam logic [PW-1:0] PS_ONE  = PW'(1'b1);
  localparam logic [3:0]    CD_INIT = 4'(COUNTDOWN_S);
  localparam logic [6:0]    PL_INIT = 7'(PLAY_S);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_PLAY  = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  state_t          state_r, state_s;
  logic [PW-1:0]   presc_r, presc_s;
  logic [3:0]      digit_r, digit_s;
  logic [6:0]      time_r, time_s;
  logic            sec_r, sec_s;
  logic            play_r, over_r;
  logic            run_s;
  logic            tick_s;

  // Prescaler enable: countdown always runs, play runs only while unpaused.
  always_comb begin
    run_s = 1'b0;
    case (state_r)
      ST_COUNT: run_s = 1'b1;
      ST_PLAY:  run_s = ~pause;
      default:  run_s = 1'b0;
    endcase
    tick_s = run_s & (presc_r == PS_LAST);
  end

  // Next-state, prescaler and counter update.
  always_comb begin
    state_s = state_r;
    presc_s = presc_r;
    digit_s = digit_r;
    time_s  = time_r;
    sec_s   = 1'b0;

    if (run_s) begin
      presc_s = tick_s ? PS_ZERO : (presc_r + PS_ONE);
    end else begin
      presc_s = presc_r;
    end

    if ((state_r != ST_IDLE) && !gamestart) begin
      // Abort wins over any tick in the same cycle.
      state_s = ST_IDLE;
      presc_s = PS_ZERO;
      digit_s = 4'd0;
      time_s  = 7'd0;
      sec_s   = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          presc_s = PS_ZERO;
          if (gamestart) begin
            state_s = ST_COUNT;
            digit_s = CD_INIT;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_COUNT: begin
          if (tick_s) begin
            sec_s = 1'b1;
            if (digit_r <= 4'd1) begin
              state_s = ST_PLAY;
              presc_s = PS_ZERO;
              digit_s = 4'd0;
              time_s  = PL_INIT;
            end else begin
              digit_s = digit_r - 4'd1;
            end
          end else begin
            sec_s = 1'b0;
          end
        end
        ST_PLAY: begin
          if (tick_s) begin
            sec_s = 1'b1;
            if (time_r <= 7'd1) begin
              state_s = ST_OVER;
              presc_s = PS_ZERO;
              time_s  = 7'd0;
            end else begin
              time_s = time_r - 7'd1;
            end
          end else begin
            sec_s = 1'b0;
          end
        end
        ST_OVER: begin
          presc_s = PS_ZERO;
          time_s  = 7'd0;
        end
        default: begin
          state_s = ST_IDLE;
          presc_s = PS_ZERO;
          digit_s = 4'd0;
          time_s  = 7'd0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      presc_r <= PS_ZERO;
      digit_r <= 4'd0;
      time_r  <= 7'd0;
      sec_r   <= 1'b0;
      play_r  <= 1'b0;
      over_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      presc_r <= presc_s;
      digit_r <= digit_s;
      time_r  <= time_s;
      sec_r   <= sec_s;
      play_r  <= (state_s == ST_PLAY);
      over_r  <= (state_s == ST_OVER);
    end
  end

  assign phase       = state_r;
  assign count_digit = digit_r;
  assign time_left   = time_r;
  assign sec_tick    = sec_r;
  assign play_en     = play_r;
  assign game_over   = over_r;

endmodule
